// File: rtl/fwd_mux_pipe.sv
// -----------------------------------------------------------------------------
// fwd_mux_pipe
//   N-source operand select for forwarding / ALU-source paths. One of NUM_SRC
//   words is picked by an encoded select. The picked word is then delayed
//   through PIPE_STAGES registers. Each register carries a valid bit, and the
//   pipeline supports stall (hold) and flush (kill). Out-of-range selects
//   saturate to the highest source. They also raise a one-cycle registered
//   pulse, and a sticky debug bit records that the pulse occurred.
//
// Parameters
//   WIDTH        data word width (>= 1)
//   NUM_SRC      number of sources (>= 2)
//   SEL_W        select width, derived from NUM_SRC (leave at default)
//   PIPE_STAGES  register stages 0..4, 0 = purely combinational data path
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   d          in   packed sources, source i = d[i*WIDTH +: WIDTH]
//   s          in   encoded select
//   in_valid   in   current selection is valid
//   stall      in   hold every stage
//   flush      in   kill every stage (wins over stall)
//   clr_err    in   clear the sticky error bit
//   y_comb     out  unregistered selected word
//   y          out  word at the last stage (y_comb when PIPE_STAGES = 0)
//   y_valid    out  valid at the last stage (in_valid when PIPE_STAGES = 0)
//   sel_oob    out  registered pulse: accepted input had s >= NUM_SRC
//   err_sticky out  set by any sel_oob, cleared by clr_err or reset
// -----------------------------------------------------------------------------
module fwd_mux_pipe #(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int PIPE_STAGES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]         s,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         y_comb,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  output logic                     sel_oob,
  output logic                     err_sticky
);

  // Reject illegal parameterisations at elaboration time.
  generate
    if (NUM_SRC < 2 || PIPE_STAGES < 0 || PIPE_STAGES > 4 || WIDTH < 1) begin : g_bad_param
      $fatal(1, "fwd_mux_pipe: illegal parameters (NUM_SRC>=2, 0<=PIPE_STAGES<=4, WIDTH>=1)");
    end
  endgenerate

  logic [WIDTH-1:0] y_comb_s;
  logic             oob_s;
  logic             oob_set_s;
  logic             sel_oob_r;
  logic             err_sticky_r;

  // Out-of-range detect. This can only be true when NUM_SRC is not a power of 2.
  always_comb begin
    oob_s = (int'(s) >= NUM_SRC);
  end

  // Source select. The default is the highest source, so out-of-range codes saturate.
  always_comb begin
    y_comb_s = d[(NUM_SRC-1)*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_SRC - 1; i++) begin
      y_comb_s = (int'(s) == i) ? d[i*WIDTH +: WIDTH] : y_comb_s;
    end
  end

  // A select counts as accepted only when it actually enters the pipeline.
  always_comb begin
    oob_set_s = in_valid & ~stall & ~flush & oob_s;
  end

  assign y_comb = y_comb_s;

  generate
    if (PIPE_STAGES == 0) begin : g_comb
      assign y       = y_comb_s;
      assign y_valid = in_valid;
    end else begin : g_pipe
      logic [WIDTH-1:0]       data_r [PIPE_STAGES];
      logic [PIPE_STAGES-1:0] valid_r;

      // Stage shift register: flush clears every stage, stall holds every stage, otherwise the stages shift.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < PIPE_STAGES; k++) data_r[k] <= '0;
          valid_r <= '0;
        end else if (flush) begin
          for (int k = 0; k < PIPE_STAGES; k++) data_r[k] <= '0;
          valid_r <= '0;
        end else if (stall) begin
          for (int k = 0; k < PIPE_STAGES; k++) data_r[k] <= data_r[k];
          valid_r <= valid_r;
        end else begin
          // Data is captured even when in_valid is low; only the valid bit gives it meaning.
          data_r[0]  <= y_comb_s;
          valid_r[0] <= in_valid;
          for (int k = 1; k < PIPE_STAGES; k++) begin
            data_r[k]  <= data_r[k-1];
            valid_r[k] <= valid_r[k-1];
          end
        end
      end

      assign y       = data_r[PIPE_STAGES-1];
      assign y_valid = valid_r[PIPE_STAGES-1];
    end
  endgenerate

  // Out-of-range pulse and sticky bit. A set on the same edge as clr_err takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_oob_r    <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      sel_oob_r <= oob_set_s;
      if (oob_set_s) begin
        err_sticky_r <= 1'b1;
      end else if (clr_err) begin
        err_sticky_r <= 1'b0;
      end else begin
        err_sticky_r <= err_sticky_r;
      end
    end
  end

  assign sel_oob    = sel_oob_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_fwd_mux_pipe
//   Directed bench for fwd_mux_pipe. Two instances share every input.
//   u0 uses NUM_SRC=3 with a combinational data path (PIPE_STAGES=0).
//   u2 uses NUM_SRC=3 with two register stages.
//   Inputs change on the falling edge, and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fwd_mux_pipe;

  localparam int W = 16;
  localparam int N = 3;

  logic           clk_s;
  logic           reset_s;
  logic [N*W-1:0] d_s;
  logic [1:0]     s_s;
  logic           in_valid_s;
  logic           stall_s;
  logic           flush_s;
  logic           clr_err_s;

  logic [W-1:0]   u0_y_comb_s, u0_y_s, u2_y_comb_s, u2_y_s;
  logic           u0_y_valid_s, u0_sel_oob_s, u0_err_s;
  logic           u2_y_valid_s, u2_sel_oob_s, u2_err_s;

  int n_cmp  = 0;
  int n_fail = 0;

  fwd_mux_pipe #(.WIDTH(W), .NUM_SRC(N), .PIPE_STAGES(0)) u0 (
    .clk(clk_s), .reset(reset_s), .d(d_s), .s(s_s), .in_valid(in_valid_s),
    .stall(stall_s), .flush(flush_s), .clr_err(clr_err_s),
    .y_comb(u0_y_comb_s), .y(u0_y_s), .y_valid(u0_y_valid_s),
    .sel_oob(u0_sel_oob_s), .err_sticky(u0_err_s)
  );

  fwd_mux_pipe #(.WIDTH(W), .NUM_SRC(N), .PIPE_STAGES(2)) u2 (
    .clk(clk_s), .reset(reset_s), .d(d_s), .s(s_s), .in_valid(in_valid_s),
    .stall(stall_s), .flush(flush_s), .clr_err(clr_err_s),
    .y_comb(u2_y_comb_s), .y(u2_y_s), .y_valid(u2_y_valid_s),
    .sel_oob(u2_sel_oob_s), .err_sticky(u2_err_s)
  );

  // Clock generator.
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  // Run-time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [W-1:0] d2, input logic [W-1:0] d1, input logic [W-1:0] d0);
    d_s = {d2, d1, d0};
  endtask

  // Directed stimulus and checks.
  initial begin
    reset_s = 1'b1; d_s = '0; s_s = 2'd0; in_valid_s = 1'b0;
    stall_s = 1'b0; flush_s = 1'b0; clr_err_s = 1'b0;

    // Reset state.
    @(negedge clk_s); @(negedge clk_s); #1;
    check("rst_u2_y",       32'(u2_y_s),       32'h0);
    check("rst_u2_y_valid", 32'(u2_y_valid_s), 32'h0);
    check("rst_u2_sel_oob", 32'(u2_sel_oob_s), 32'h0);
    check("rst_u2_err",     32'(u2_err_s),     32'h0);
    check("rst_u0_err",     32'(u0_err_s),     32'h0);

    // T1: combinational select with saturation, on u0.
    @(negedge clk_s);
    reset_s = 1'b0; set_d(16'd30, 16'd20, 16'd10);
    in_valid_s = 1'b1; s_s = 2'd0; #1;
    check("t1_s0_y",       32'(u0_y_s),       32'd10);
    check("t1_s0_y_valid", 32'(u0_y_valid_s), 32'h1);
    check("t1_s0_y_comb",  32'(u0_y_comb_s),  32'd10);
    @(negedge clk_s); s_s = 2'd1; #1;
    check("t1_s1_y",       32'(u0_y_s),       32'd20);
    check("t1_no_oob",     32'(u0_sel_oob_s), 32'h0);
    @(negedge clk_s); s_s = 2'd2; #1;
    check("t1_s2_y",       32'(u0_y_s),       32'd30);
    @(negedge clk_s); s_s = 2'd3; #1;
    check("t1_s3_y_sat",   32'(u0_y_s),       32'd30);
    check("t1_s3_oob_pre", 32'(u0_sel_oob_s), 32'h0);
    @(negedge clk_s); s_s = 2'd3; in_valid_s = 1'b0; #1;
    check("t1_oob_pulse",  32'(u0_sel_oob_s), 32'h1);
    check("t1_err_set",    32'(u0_err_s),     32'h1);
    @(negedge clk_s); s_s = 2'd0; #1;
    check("t1_oob_1cyc",   32'(u0_sel_oob_s), 32'h0);
    check("t1_oob_invalid_sel", 32'(u0_err_s), 32'h1);

    // Clean up between tests: flush the pipeline and clear the sticky bit.
    flush_s = 1'b1; clr_err_s = 1'b1;
    @(negedge clk_s); flush_s = 1'b0; clr_err_s = 1'b0; #1;
    check("clean_err",     32'(u0_err_s),     32'h0);
    check("clean_y_valid", 32'(u2_y_valid_s), 32'h0);

    // T2: latency of two cycles on u2.
    set_d(16'd30, 16'hA5A5, 16'd10); s_s = 2'd1; in_valid_s = 1'b1; #1;
    check("t2_c0_y_valid", 32'(u2_y_valid_s), 32'h0);
    @(negedge clk_s); in_valid_s = 1'b0; #1;
    check("t2_c1_y_valid", 32'(u2_y_valid_s), 32'h0);
    @(negedge clk_s); #1;
    check("t2_c2_y",       32'(u2_y_s),       32'hA5A5);
    check("t2_c2_y_valid", 32'(u2_y_valid_s), 32'h1);
    @(negedge clk_s); #1;
    check("t2_c3_y_valid", 32'(u2_y_valid_s), 32'h0);

    // T3: stream 1,2,3 with three stalled edges in mid-stream.
    s_s = 2'd0; set_d(16'd30, 16'hA5A5, 16'd1); in_valid_s = 1'b1;
    @(negedge clk_s); set_d(16'd30, 16'hA5A5, 16'd2);
    @(negedge clk_s); set_d(16'd30, 16'hA5A5, 16'd3); #1;
    check("t3_y1",         32'(u2_y_s),       32'd1);
    check("t3_y1_valid",   32'(u2_y_valid_s), 32'h1);
    stall_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_s); #1;
      check("t3_hold_y",       32'(u2_y_s),       32'd1);
      check("t3_hold_y_valid", 32'(u2_y_valid_s), 32'h1);
    end
    stall_s = 1'b0;
    @(negedge clk_s); in_valid_s = 1'b0; #1;
    check("t3_y2",         32'(u2_y_s),       32'd2);
    check("t3_y2_valid",   32'(u2_y_valid_s), 32'h1);
    @(negedge clk_s); #1;
    check("t3_y3",         32'(u2_y_s),       32'd3);
    check("t3_y3_valid",   32'(u2_y_valid_s), 32'h1);
    @(negedge clk_s); #1;
    check("t3_drain",      32'(u2_y_valid_s), 32'h0);

    // T4: flush and stall together, with two valid words in flight.
    set_d(16'd30, 16'hA5A5, 16'd7); in_valid_s = 1'b1;
    @(negedge clk_s); set_d(16'd30, 16'hA5A5, 16'd8);
    @(negedge clk_s); #1;
    check("t4_pre_y",      32'(u2_y_s),       32'd7);
    flush_s = 1'b1; stall_s = 1'b1; s_s = 2'd3;
    @(negedge clk_s); flush_s = 1'b0; stall_s = 1'b0; in_valid_s = 1'b0; s_s = 2'd0; #1;
    check("t4_y",          32'(u2_y_s),       32'h0);
    check("t4_y_valid",    32'(u2_y_valid_s), 32'h0);
    check("t4_no_oob",     32'(u2_sel_oob_s), 32'h0);
    check("t4_no_err",     32'(u2_err_s),     32'h0);
    @(negedge clk_s); #1;
    check("t4_st0_y",      32'(u2_y_s),       32'h0);
    check("t4_st0_valid",  32'(u2_y_valid_s), 32'h0);

    // T5: sticky error behaviour.
    s_s = 2'd3; in_valid_s = 1'b1;
    @(negedge clk_s); s_s = 2'd0; #1;
    check("t5_oob",        32'(u2_sel_oob_s), 32'h1);
    check("t5_err",        32'(u2_err_s),     32'h1);
    @(negedge clk_s); #1;
    check("t5_oob_drop",   32'(u2_sel_oob_s), 32'h0);
    check("t5_err_stays",  32'(u2_err_s),     32'h1);
    clr_err_s = 1'b1;
    @(negedge clk_s); #1;
    check("t5_err_clr",    32'(u2_err_s),     32'h0);
    s_s = 2'd3;
    @(negedge clk_s); clr_err_s = 1'b0; stall_s = 1'b1; #1;
    check("t5_set_wins",   32'(u2_err_s),     32'h1);
    check("t5_set_oob",    32'(u2_sel_oob_s), 32'h1);
    @(negedge clk_s); stall_s = 1'b0; in_valid_s = 1'b0; s_s = 2'd0; #1;
    check("t5_stall_no_oob", 32'(u2_sel_oob_s), 32'h0);
    check("t5_err_held",   32'(u0_err_s),     32'h1);

    // T6: asynchronous reset between edges while stalled with valid data.
    set_d(16'd30, 16'hA5A5, 16'd5); in_valid_s = 1'b1;
    @(negedge clk_s); set_d(16'd30, 16'hA5A5, 16'd6);
    @(negedge clk_s); stall_s = 1'b1; #1;
    check("t6_pre_y",      32'(u2_y_s),       32'd5);
    @(negedge clk_s); #1;
    check("t6_stall_y",    32'(u2_y_s),       32'd5);
    check("t6_stall_err",  32'(u2_err_s),     32'h1);
    #1 reset_s = 1'b1; #1;
    check("t6_rst_y",       32'(u2_y_s),       32'h0);
    check("t6_rst_y_valid", 32'(u2_y_valid_s), 32'h0);
    check("t6_rst_err",     32'(u2_err_s),     32'h0);
    check("t6_rst_y_comb",  32'(u2_y_comb_s),  32'd6);
    @(negedge clk_s);
    reset_s = 1'b0; stall_s = 1'b0; set_d(16'd30, 16'hA5A5, 16'h11); in_valid_s = 1'b1;
    @(negedge clk_s); in_valid_s = 1'b0; #1;
    check("t6_rel_y_valid", 32'(u2_y_valid_s), 32'h0);
    @(negedge clk_s); #1;
    check("t6_rel_y",       32'(u2_y_s),       32'h11);
    check("t6_rel_valid",   32'(u2_y_valid_s), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
